mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that turns 32-bit word requests into four
// little-endian byte beats on an 8-bit memory bus, each held BEAT_CYCLES clocks.
module mem_arbiter #(
  parameter int BEAT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_we,
  input  logic        r1_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r1_wdata,
  output logic        r0_ack,
  output logic        r1_ack,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BEAT_LAST = 4'(BEAT_CYCLES - 1);

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [23:0] put_byte(input logic [23:0] a, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [23:0] r;
    r = a;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      default: r[23:16] = b;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] r0_rdata_q, r0_rdata_d;
  logic [31:0] r1_rdata_q, r1_rdata_d;
  logic        r0_ack_q, r0_ack_d;
  logic        r1_ack_q, r1_ack_d;
  logic        mem_cs_q, mem_cs_d;
  logic        mem_oe_q, mem_oe_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_wdata_oe_q, mem_wdata_oe_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        beat_s;

  // Next-state, arbitration, byte assembly; bus outputs are decoded from the
  // next state so they register in the same cycle the FSM enters it.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          gnt_d   = (r0_req && r1_req) ? ~last_q : r1_req;
          last_d  = gnt_d;
          we_d    = gnt_d ? r1_we : r0_we;
          addr_d  = (gnt_d ? r1_addr : r0_addr) & 32'hFFFF_FFFC;
          wdata_d = gnt_d ? r1_wdata : r0_wdata;
          k_d     = 2'd0;
          cnt_d   = 4'd0;
          state_d = BEAT;
        end else begin
          state_d = IDLE;
        end
      end
      BEAT: begin
        if (cnt_q == BEAT_LAST) begin
          cnt_d = 4'd0;
          if (k_q == 2'd3) begin
            state_d = DONE;
            if (!we_q && gnt_q) begin
              r1_rdata_d = {mem_rdata, asm_q};
            end else if (!we_q) begin
              r0_rdata_d = {mem_rdata, asm_q};
            end else begin
              r0_rdata_d = r0_rdata_q;
            end
          end else begin
            k_d = k_q + 2'd1;
            if (!we_q) begin
              asm_d = put_byte(asm_q, k_q, mem_rdata);
            end else begin
              asm_d = asm_q;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    beat_s         = (state_d == BEAT);
    mem_cs_d       = beat_s;
    mem_we_d       = beat_s && we_d;
    mem_oe_d       = beat_s && !we_d;
    mem_wdata_oe_d = beat_s && we_d;
    mem_addr_d     = beat_s ? (addr_d + {30'd0, k_d}) : 32'h0;
    mem_wdata_d    = (beat_s && we_d) ? byte_sel(wdata_d, k_d) : 8'h00;
    r0_ack_d       = (state_d == DONE) && !gnt_d;
    r1_ack_d       = (state_d == DONE) && gnt_d;
  end

  // State and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      k_q            <= 2'd0;
      cnt_q          <= 4'd0;
      gnt_q          <= 1'b0;
      last_q         <= 1'b1;
      we_q           <= 1'b0;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      asm_q          <= 24'h0;
      r0_rdata_q     <= 32'h0;
      r1_rdata_q     <= 32'h0;
      r0_ack_q       <= 1'b0;
      r1_ack_q       <= 1'b0;
      mem_cs_q       <= 1'b0;
      mem_oe_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_wdata_oe_q <= 1'b0;
      mem_addr_q     <= 32'h0;
      mem_wdata_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      cnt_q          <= cnt_d;
      gnt_q          <= gnt_d;
      last_q         <= last_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      asm_q          <= asm_d;
      r0_rdata_q     <= r0_rdata_d;
      r1_rdata_q     <= r1_rdata_d;
      r0_ack_q       <= r0_ack_d;
      r1_ack_q       <= r1_ack_d;
      mem_cs_q       <= mem_cs_d;
      mem_oe_q       <= mem_oe_d;
      mem_we_q       <= mem_we_d;
      mem_wdata_oe_q <= mem_wdata_oe_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign r0_ack       = r0_ack_q;
  assign r1_ack       = r1_ack_q;
  assign r0_rdata     = r0_rdata_q;
  assign r1_rdata     = r1_rdata_q;
  assign mem_cs       = mem_cs_q;
  assign mem_oe       = mem_oe_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata_oe = mem_wdata_oe_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-memory model, ack scoreboard, bus-beat log,
// vector table plus tie, mid-transfer reset and BEAT_CYCLES=3 sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        r0_req = 1'b0, r1_req = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
  logic [31:0] r0_addr = 32'h0, r1_addr = 32'h0, r0_wdata = 32'h0, r1_wdata = 32'h0;
  logic        r0_ack, r1_ack, mem_cs, mem_oe, mem_we, mem_wdata_oe;
  logic [31:0] r0_rdata, r1_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        q_req = 1'b0, q_we = 1'b0;
  logic [31:0] q_addr = 32'h0, q_wdata = 32'h0;
  logic        q_ack, n_ack, m3_cs, m3_oe, m3_we, m3_wdata_oe;
  logic [31:0] q_rdata, n_rdata, m3_addr;
  logic [7:0]  m3_wdata, m3_rdata;

  mem_arbiter #(.BEAT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_ack(r0_ack), .r1_ack(r1_ack), .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.BEAT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .r0_req(q_req), .r1_req(1'b0), .r0_we(q_we), .r1_we(1'b0),
    .r0_addr(q_addr), .r1_addr(32'h0), .r0_wdata(q_wdata), .r1_wdata(32'h0),
    .r0_ack(q_ack), .r1_ack(n_ack), .r0_rdata(q_rdata), .r1_rdata(n_rdata),
    .mem_cs(m3_cs), .mem_oe(m3_oe), .mem_we(m3_we), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_wdata_oe(m3_wdata_oe), .mem_rdata(m3_rdata)
  );

  // Sparse byte memory: only the address windows the test uses are distinct.
  logic [7:0] mem [0:15];
  function automatic logic [3:0] midx(input logic [31:0] a);
    return {a[31], a[3], a[1:0]};
  endfunction
  assign mem_rdata = mem_oe ? mem[midx(mem_addr)] : 8'h00;
  always @(posedge clk) if (mem_cs && mem_we) mem[midx(mem_addr)] <= mem_wdata;
  assign m3_rdata = m3_oe ? (m3_addr[7:0] ^ 8'h5A) : 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int port; logic rd; logic [31:0] rdata; int exp_cyc;} sb_t;
  typedef struct {logic [31:0] addr; logic we; logic [7:0] wdata;} beat_t;
  typedef struct {int port; logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp;} vec_t;
  sb_t   sb[$];
  beat_t blog[$];
  beat_t blog3[$];
  logic [31:0] rd_model [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus logging, protocol invariants and ack scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_cs) blog.push_back('{mem_addr, mem_we, mem_wdata});
    if (m3_cs) blog3.push_back('{m3_addr, m3_we, m3_wdata});
    chk("bus_protocol",
        {31'd0, (mem_oe && mem_we) || (mem_wdata_oe !== mem_we) || (r0_ack && r1_ack) ||
                (!mem_cs && (mem_oe || mem_we || mem_wdata_oe))}, 32'd0);
    if (r0_ack || r1_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("ack_port", {31'd0, r1_ack}, e.port);
        chk("ack_cycle", cyc, e.exp_cyc);
        if (e.rd) chk("ack_rdata", (e.port == 1) ? r1_rdata : r0_rdata, e.rdata);
      end
    end
  end

  task automatic drive(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    if (p == 0) begin r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
    else        begin r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      got = (p == 0) ? r0_ack : r1_ack;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (p == 0) r0_req = 1'b0; else r1_req = 1'b0;
  endtask

  task automatic chk_bus(input int which, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input int bc);
    beat_t q[$];
    logic [31:0] w;
    int k;
    q = (which == 1) ? blog3 : blog;
    chk("bus_beats", q.size(), 4 * bc);
    for (int i = 0; i < q.size() && i < 4 * bc; i++) begin
      k = i / bc;
      w = wdata >> (8 * k);
      chk("bus_addr", q[i].addr, (addr & 32'hFFFF_FFFC) + k);
      chk("bus_we", {31'd0, q[i].we}, {31'd0, we});
      if (we) chk("bus_wdata", {24'd0, q[i].wdata}, {24'd0, w[7:0]});
    end
  endtask

  task automatic chk_hold();
    chk("r0_rdata_hold", r0_rdata, rd_model[0]);
    chk("r1_rdata_hold", r1_rdata, rd_model[1]);
  endtask

  task automatic single(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp);
    @(posedge clk); #1;
    blog.delete();
    sb.push_back('{p, !we, exp, cyc + 5});
    drive(p, we, addr, wdata);
    chk_bus(0, addr, we, wdata, 1);
    if (!we) rd_model[p] = exp;
    chk_hold();
  endtask

  task automatic bc3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp);
    int t0, acyc;
    logic got;
    @(posedge clk); #1;
    t0 = cyc; acyc = 0; got = 1'b0;
    blog3.delete();
    q_req = 1'b1; q_we = we; q_addr = addr; q_wdata = wdata;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (q_ack) begin got = 1'b1; acyc = cyc; end
    end
    chk("bc3_ack_cycle", acyc, t0 + 13);
    if (!we) chk("bc3_rdata", q_rdata, exp);
    @(posedge clk); #1;
    q_req = 1'b0;
    chk_bus(1, addr, we, wdata, 3);
  endtask

  vec_t vt [7];
  int   t0;

  initial begin
    vt[0] = '{0, 1'b1, 32'h0000_0100, 32'hA1B2_C3D4, 32'h0};
    vt[1] = '{1, 1'b0, 32'h0000_0100, 32'h0,         32'hA1B2_C3D4};
    vt[2] = '{1, 1'b1, 32'h0000_0208, 32'h0F1E_2D3C, 32'h0};
    vt[3] = '{0, 1'b0, 32'h0000_020A, 32'h0,         32'h0F1E_2D3C};
    vt[4] = '{0, 1'b1, 32'hFFFF_FFFF, 32'h5566_7788, 32'h0};
    vt[5] = '{1, 1'b0, 32'hFFFF_FFFD, 32'h0,         32'h5566_7788};
    vt[6] = '{0, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h5566_7788};
    rd_model[0] = 32'h0;
    rd_model[1] = 32'h0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus", {mem_cs, mem_oe, mem_we, mem_wdata_oe, mem_wdata, mem_addr[21:0]}, 32'd0);
    chk("rst_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
    chk_hold();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Tie from reset: r0 first, r1 granted two cycles after r0's ack.
    @(posedge clk); #1;
    t0 = cyc;
    sb.push_back('{0, 1'b0, 32'h0, t0 + 5});
    sb.push_back('{1, 1'b1, 32'h0102_0304, t0 + 11});
    fork
      drive(0, 1'b1, 32'h0000_0208, 32'h0102_0304);
      drive(1, 1'b0, 32'h0000_0208, 32'h0);
    join
    rd_model[1] = 32'h0102_0304;
    chk_hold();

    // Reset during beat 2 of a write: bytes 0,1 land, bytes 2,3 keep old data.
    @(posedge clk); #1;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h0000_0208; r0_wdata = 32'h1122_3344;
    for (int i = 0; i < 20 && !(mem_cs && mem_addr == 32'h0000_020A); i++) @(negedge clk);
    chk("reached_beat2", mem_addr, 32'h0000_020A);
    rst_n = 1'b0;
    r0_req = 1'b0;
    #1;
    chk("mid_rst_bus", {mem_cs, mem_oe, mem_we, mem_wdata_oe, mem_wdata, mem_addr[21:0]}, 32'd0);
    chk("mid_rst_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
    rd_model[0] = 32'h0;
    rd_model[1] = 32'h0;
    chk_hold();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    blog.delete();
    repeat (5) @(posedge clk);
    #1 chk("idle_after_reset", blog.size(), 32'd0);
    single(0, 1'b0, 32'h0000_0208, 32'h0, 32'h0102_3344);

    for (int i = 0; i < 7; i++) single(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);

    // Last grant was r0, so this tie goes to r1 first.
    @(posedge clk); #1;
    t0 = cyc;
    sb.push_back('{1, 1'b0, 32'h0, t0 + 5});
    sb.push_back('{0, 1'b1, 32'hCAFE_F00D, t0 + 11});
    fork
      drive(1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);
      drive(0, 1'b0, 32'h0000_0100, 32'h0);
    join
    rd_model[0] = 32'hCAFE_F00D;
    chk_hold();

    bc3(1'b1, 32'h0000_0040, 32'h9988_7766, 32'h0);
    bc3(1'b0, 32'h0000_0041, 32'h0, 32'h1918_1B1A);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
